uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_picker.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared definitions for the UART transmit arbiter.
//   - default values of NREQ, DATA_W and BUSY_TO
//   - state encoding of the arbiter FSM
package uart_arb_pkg;

    localparam int NREQ_DEFAULT    = 4;
    localparam int DATA_W_DEFAULT  = 8;
    localparam int BUSY_TO_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ACK       = 3'd4
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search.
//   req        in  NREQ   request vector
//   last_grant in  GW     most recently served requester
//   valid      out 1      some request is pending
//   index      out GW     first pending requester after last_grant (wrapping)
module rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] index
);

    localparam int GW = $clog2(NREQ);

    logic [GW-1:0] cand;

    // k = 1..NREQ visits last_grant+1 first and last_grant itself last,
    // which is what keeps a requester that never drops req from starving others.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NREQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NREQ requesters.
//   clk, rst_n   clock, asynchronous active-low reset
//   req          per-requester request level, held until ack
//   req_data     requester i's byte at [i*DATA_W +: DATA_W]
//   ack          one-cycle pulse to the served requester
//   tx_start     one-cycle start pulse to the transmitter
//   tx_data      latched byte, stable from tx_start until ack
//   tx_busy      transmitter busy level
//   grant_id     requester being served
//   busy         high whenever the FSM is not idle
//   timeout      one-cycle pulse when tx_busy never rose
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | waiting for any req; winner latched on leaving
// START      | tx_start high for this single cycle
// WAIT_BUSY  | waiting for tx_busy to rise, bounded by BUSY_TO
// WAIT_DONE  | waiting for tx_busy to fall
// ACK        | ack[grant_id] high, last_grant updated
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int BUSY_TO = BUSY_TO_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          ack,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     timeout
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(BUSY_TO + 1);

    arb_state_t        state_q, state_d;
    logic [GW-1:0]     grant_id_q, grant_id_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              tx_start_q, tx_start_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, busy_d;

    logic              pick_valid;
    logic [GW-1:0]     pick_idx;
    logic [DATA_W-1:0] pick_data;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == GW'(i)) begin
                pick_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // cnt_q is the timeout down-counter: loaded with BUSY_TO when a grant is
    // made, decremented from START onward. The cycle in which it sits at zero
    // in WAIT_BUSY is the timeout cycle; the FSM leaves for ACK at its end.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        tx_data_d    = tx_data_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_START;
                    grant_id_d = pick_idx;
                    tx_data_d  = pick_data;
                    cnt_d      = CW'(BUSY_TO);
                end
            end
            ST_START: begin
                state_d = ST_WAIT_BUSY;
                cnt_d   = cnt_q - CW'(1);
            end
            ST_WAIT_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                end else if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d      = ST_IDLE;
                last_grant_d = grant_id_q;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered
        // in the same cycle the FSM occupies that state.
        tx_start_d = (state_d == ST_START);
        busy_d     = (state_d != ST_IDLE);
        timeout_d  = (state_d == ST_WAIT_BUSY) && (cnt_d == '0);
        ack_d      = '0;
        if (state_d == ST_ACK) begin
            ack_d[grant_id_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= GW'(NREQ - 1);
            tx_data_q    <= '0;
            cnt_q        <= '0;
            ack_q        <= '0;
            tx_start_q   <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            tx_data_q    <= tx_data_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            tx_start_q   <= tx_start_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a
// transaction-level reference model and per-cycle output comparison.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int BT   = 4;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              tx_start;
    logic [DW-1:0]     tx_data;
    logic              tx_busy;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .DATA_W  (DW),
        .BUSY_TO (BT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---------------- reference model ----------------
    // Tracks one transaction by cycle stamps: the start cycle, whether
    // tx_busy has been seen, and the cycle in which ack is due.
    int              m_active, m_gnt, m_last, m_start_at, m_ack_at, m_seen;
    int              mc, mn, mj, m_found;
    logic [DW-1:0]   m_data;
    logic [NREQ-1:0] e_ack;
    logic            e_start, e_to, e_busy;
    logic [1:0]      e_gid;
    logic [DW-1:0]   e_data;

    initial begin
        m_active = 0; m_gnt = 0; m_last = NREQ-1; m_start_at = -1000;
        m_ack_at = -1; m_seen = 0; m_data = '0;
        e_ack = '0; e_start = 0; e_to = 0; e_busy = 0; e_gid = '0; e_data = '0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_last = NREQ-1; m_ack_at = -1; m_seen = 0;
            m_gnt = 0; m_data = '0; m_start_at = -1000;
            e_ack = '0; e_start = 0; e_to = 0; e_busy = 0; e_gid = '0; e_data = '0;
        end else begin
            mc = cyc;
            mn = cyc + 1;
            e_start = 0;
            e_to    = 0;
            e_ack   = '0;
            if (m_active != 0 && m_ack_at == mc) begin
                m_last   = m_gnt;
                m_active = 0;
            end else if (m_active == 0) begin
                m_found = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    mj = (m_last + k) % NREQ;
                    if (m_found == 0 && req[mj]) begin
                        m_found = 1;
                        m_gnt   = mj;
                    end
                end
                if (m_found != 0) begin
                    m_active   = 1;
                    m_data     = req_data[m_gnt*DW +: DW];
                    m_start_at = mn;
                    m_seen     = 0;
                    m_ack_at   = -1;
                    e_start    = 1;
                end
            end else if (mc == m_start_at) begin
                if (mn == m_start_at + BT) e_to = 1;
            end else if (m_seen == 0) begin
                if (mc == m_start_at + BT)      m_ack_at = mn;
                else if (tx_busy)               m_seen = 1;
                else if (mn == m_start_at + BT) e_to = 1;
            end else if (!tx_busy) begin
                m_ack_at = mn;
            end
            if (m_ack_at == mn) e_ack = NREQ'(1) << m_gnt;
            e_busy = (m_active != 0);
            e_gid  = 2'(m_gnt);
            e_data = m_data;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (ack !== e_ack || tx_start !== e_start || timeout !== e_to ||
            busy !== e_busy || grant_id !== e_gid || tx_data !== e_data) begin
            errors++;
            $display("FAIL cycle_model cyc=%0d got ack=%b start=%b to=%b busy=%b gid=%0d data=%h expected ack=%b start=%b to=%b busy=%b gid=%0d data=%h",
                     cyc, ack, tx_start, timeout, busy, grant_id, tx_data,
                     e_ack, e_start, e_to, e_busy, e_gid, e_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [NREQ-1:0] auto_drop;
    int busy_dly, busy_len, uart_dead, busy_force;
    int s_cyc, to_cyc, ack_cyc, ack_count, start_seen, rel;
    logic [NREQ-1:0] ack_vec;
    logic [DW-1:0]   start_data, ack_data;
    int grant_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: observe the DUT just after the edge, emulate the UART,
    // and let requesters in auto_drop release req on their own ack.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_start) begin
            s_cyc      = cyc;
            start_seen++;
            start_data = tx_data;
        end
        if (timeout) to_cyc = cyc;
        if (ack != '0) begin
            ack_cyc  = cyc;
            ack_vec  = ack;
            ack_data = tx_data;
            ack_count++;
            for (int i = 0; i < NREQ; i++) if (ack[i]) grant_log.push_back(i);
            req = req & ~(ack & auto_drop);
        end
        rel     = cyc - s_cyc;
        tx_busy = (busy_force != 0) ||
                  (uart_dead == 0 && rel >= busy_dly && rel < busy_dly + busy_len);
    endtask

    task automatic wait_acks(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (ack_count < target && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(ack_count >= target), 32'd1);
    endtask

    task automatic wait_starts(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (start_seen < target && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(start_seen >= target), 32'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int base, c0;

    initial begin
        rst_n = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0;
        auto_drop = '1; busy_dly = 1; busy_len = 1; uart_dead = 0; busy_force = 0;
        s_cyc = -1000; to_cyc = -1; ack_cyc = -1; ack_count = 0; start_seen = 0;
        ack_vec = '0; start_data = '0; ack_data = '0;

        // reset values
        repeat (3) tick();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        tick();

        // single request, transmitter busy for 10 cycles
        req_data[7:0] = 8'hA5; busy_dly = 1; busy_len = 10;
        base = ack_count; start_seen = 0;
        req = 4'b0001; c0 = cyc;
        wait_acks("single_ack_wait", base + 1, 60);
        chk("single_latency", 32'(s_cyc - c0), 32'd1);
        chk("single_data", 32'(start_data), 32'hA5);
        chk("single_ack_vec", 32'(ack_vec), 32'b0001);
        chk("single_ack_time", 32'(ack_cyc - s_cyc), 32'd12);
        chk("single_one_start", 32'(start_seen), 32'd1);
        repeat (3) tick();

        // all four requesting, order from reset
        pulse_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11}; busy_dly = 2; busy_len = 3;
        grant_log.delete(); base = ack_count;
        req = 4'b1111;
        wait_acks("all_ack_wait", base + 4, 200);
        chk("all_count", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            chk("all_order0", 32'(grant_log[0]), 32'd0);
            chk("all_order1", 32'(grant_log[1]), 32'd1);
            chk("all_order2", 32'(grant_log[2]), 32'd2);
            chk("all_order3", 32'(grant_log[3]), 32'd3);
        end
        chk("all_req_clear", 32'(req), 32'h0);
        repeat (3) tick();

        // hog: req0 never releases on ack, req2 arrives during req0's transfer
        auto_drop = 4'b0100; grant_log.delete(); base = ack_count; start_seen = 0;
        req = 4'b0001;
        wait_starts("hog_first_start", 1, 20);
        req[2] = 1'b1;
        wait_starts("hog_third_start", 3, 200);
        req[0] = 1'b0;
        wait_acks("hog_ack_wait", base + 3, 100);
        repeat (4) tick();
        chk("hog_ack_total", 32'(ack_count - base), 32'd3);
        if (grant_log.size() == 3) begin
            chk("hog_order0", 32'(grant_log[0]), 32'd0);
            chk("hog_order1", 32'(grant_log[1]), 32'd2);
            chk("hog_order2", 32'(grant_log[2]), 32'd0);
        end else begin
            chk("hog_count", 32'(grant_log.size()), 32'd3);
        end

        // timeout: transmitter never raises busy
        auto_drop = '1; uart_dead = 1; base = ack_count; to_cyc = -1;
        req = 4'b0100;
        wait_acks("to_ack_wait", base + 1, 40);
        chk("to_delay", 32'(to_cyc - s_cyc), 32'd4);
        chk("to_ack_after", 32'(ack_cyc - to_cyc), 32'd1);
        chk("to_ack_vec", 32'(ack_vec), 32'b0100);
        uart_dead = 0;
        repeat (3) tick();

        // data stability after grant
        req_data[7:0] = 8'h3C; busy_dly = 1; busy_len = 5;
        base = ack_count; start_seen = 0;
        req = 4'b0001;
        wait_starts("stab_start", 1, 20);
        req_data[7:0] = 8'h00;
        wait_acks("stab_ack_wait", base + 1, 40);
        chk("stab_start_data", 32'(start_data), 32'h3C);
        chk("stab_ack_data", 32'(ack_data), 32'h3C);
        repeat (3) tick();

        // reset during WAIT_DONE; tx_busy still high when arbitration resumes
        busy_dly = 1; busy_len = 20; start_seen = 0;
        req = 4'b0010;
        wait_starts("rst_mid_start", 1, 20);
        repeat (4) tick();
        rst_n = 1'b0; base = ack_count;
        repeat (2) tick();
        chk("rst_mid_ack", 32'(ack), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_tx_start", 32'(tx_start), 32'h0);
        chk("rst_mid_tx_data", 32'(tx_data), 32'h0);
        chk("rst_mid_grant", 32'(grant_id), 32'h0);
        req = 4'b1000;
        rst_n = 1'b1;
        wait_starts("rst_after_start", 2, 20);
        chk("rst_after_grant", 32'(grant_id), 32'd3);
        chk("rst_no_ack", 32'(ack_count - base), 32'd0);
        wait_acks("rst_after_ack", base + 1, 60);
        chk("rst_after_ack_vec", 32'(ack_vec), 32'b1000);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
